// File: rtl/fifo_burst_writer.sv
// Burst writer that streams an incrementing data sequence into a FIFO and tracks a running XOR checksum.
// Optional feature: define FIFO_WRITER_AF_THROTTLE_EN to also stall on fifo_almost_full.
module fifo_burst_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  wr_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  fifo_full,
    input  logic                  fifo_almost_full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_written,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = LEN_WIDTH'(0);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [LEN_WIDTH-1:0]  r_words;
    logic [DATA_WIDTH-1:0] r_checksum;
    logic                  w_throttle;
    logic                  w_accept;
    logic                  w_wr_en;

`ifdef FIFO_WRITER_AF_THROTTLE_EN
    assign w_throttle = fifo_almost_full;
`else
    // Almost-full is deliberately ignored in this build; only fifo_full stalls.
    assign w_throttle = fifo_almost_full & 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) & start & ~abort;
    assign w_wr_en  = (r_state == ST_WRITE) & ~fifo_full & ~abort & reset & ~w_throttle;

    assign wr_en         = w_wr_en;
    assign data_in       = r_data;
    assign busy          = (r_state == ST_WRITE) | (r_state == ST_DONE);
    assign done          = (r_state == ST_DONE);
    assign words_written = r_words;
    assign checksum      = r_checksum;

    // State register
    always_ff @(posedge wr_clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (burst_len != LEN_ZERO) ? ST_WRITE : ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_wr_en && (r_remaining == LEN_ONE)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Data, counters and checksum; a stalled WRITE cycle holds everything
    always_ff @(posedge wr_clock) begin
        if (!reset) begin
            r_data      <= DATA_ZERO;
            r_remaining <= LEN_ZERO;
            r_words     <= LEN_ZERO;
            r_checksum  <= DATA_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_words    <= LEN_ZERO;
                        r_checksum <= DATA_ZERO;
                        if (burst_len != LEN_ZERO) begin
                            r_data      <= seed;
                            r_remaining <= burst_len;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_wr_en) begin
                        r_data      <= r_data + DATA_ONE;
                        r_remaining <= r_remaining - LEN_ONE;
                        r_words     <= r_words + LEN_ONE;
                        r_checksum  <= r_checksum ^ r_data;
                    end
                end
                default: begin
                    r_data <= r_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Scoreboard bench for fifo_burst_writer: stimulus queues expected words and completions, a monitor checks them.
module tb_fifo_burst_writer;

    logic        wr_clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [3:0]  burst_len;
    logic [31:0] seed;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic        wr_en;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [3:0]  words_written;
    logic [31:0] checksum;

    int checks;
    int failures;

    logic [31:0] exp_data_q[$];
    logic [3:0]  exp_words_q[$];
    logic [31:0] exp_sum_q[$];
    logic [31:0] mon_data;
    logic [3:0]  mon_words;
    logic [31:0] mon_sum;

    fifo_burst_writer #(.DATA_WIDTH(32), .LEN_WIDTH(4)) dut (
        .wr_clock         (wr_clock),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .burst_len        (burst_len),
        .seed             (seed),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .wr_en            (wr_en),
        .data_in          (data_in),
        .busy             (busy),
        .done             (done),
        .words_written    (words_written),
        .checksum         (checksum)
    );

    initial wr_clock = 1'b0;
    always #5 wr_clock = ~wr_clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write and every completion pulse is matched against the scoreboard
    always @(negedge wr_clock) begin
        if (wr_en === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h required=no_write", data_in);
            end else begin
                mon_data = exp_data_q.pop_front();
                check32("write_data", data_in, mon_data);
            end
        end
        if (done === 1'b1) begin
            if (exp_words_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_words = exp_words_q.pop_front();
                mon_sum   = exp_sum_q.pop_front();
                check32("done_words", {28'd0, words_written}, {28'd0, mon_words});
                check32("done_checksum", checksum, mon_sum);
            end
        end
    end

    task automatic push_word(input logic [31:0] d);
        exp_data_q.push_back(d);
    endtask

    task automatic push_done(input logic [3:0] w, input logic [31:0] s);
        exp_words_q.push_back(w);
        exp_sum_q.push_back(s);
    endtask

    task automatic do_start(input logic [3:0] len, input logic [31:0] sd);
        start     = 1'b1;
        burst_len = len;
        seed      = sd;
        @(posedge wr_clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge wr_clock);
            if (done === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        @(posedge wr_clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        burst_len        = 4'd0;
        seed             = 32'd0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;

        repeat (3) @(posedge wr_clock);
        @(negedge wr_clock);
        check32("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_done", {31'd0, done}, 32'd0);
        check32("rst_data", data_in, 32'd0);
        check32("rst_words", {28'd0, words_written}, 32'd0);
        check32("rst_checksum", checksum, 32'd0);
        @(posedge wr_clock);
        #1;
        reset = 1'b1;
        @(posedge wr_clock);
        #1;

        // Basic burst: four back-to-back writes, then done
        for (int i = 0; i < 4; i++) push_word(32'd10 + 32'(i));
        push_done(4'd4, 32'd0);
        do_start(4'd4, 32'd10);
        for (int i = 0; i < 4; i++) begin
            @(negedge wr_clock);
            check32("burst4_wr_en", {31'd0, wr_en}, 32'd1);
        end
        @(negedge wr_clock);
        check32("burst4_done", {31'd0, done}, 32'd1);
        check32("burst4_done_no_wr", {31'd0, wr_en}, 32'd0);
        @(posedge wr_clock);
        #1;
        check32("burst4_idle_busy", {31'd0, busy}, 32'd0);

        // Full stall in the middle of an 8-word burst
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        push_done(4'd8, 32'd8);
        do_start(4'd8, 32'd1);
        @(posedge wr_clock);
        #1;
        @(posedge wr_clock);
        #1;
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clock);
            check32("stall_wr_en", {31'd0, wr_en}, 32'd0);
            check32("stall_data_hold", data_in, 32'd3);
            @(posedge wr_clock);
            #1;
        end
        fifo_full = 1'b0;
        wait_done("stall_burst");

        // Abort after two writes, then an immediate restart
        push_word(32'd100);
        push_word(32'd101);
        do_start(4'd6, 32'd100);
        @(posedge wr_clock);
        #1;
        @(posedge wr_clock);
        #1;
        abort = 1'b1;
        @(negedge wr_clock);
        check32("abort_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge wr_clock);
        #1;
        abort = 1'b0;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_words", {28'd0, words_written}, 32'd2);
        check32("abort_checksum", checksum, 32'd1);
        push_word(32'd20);
        push_word(32'd21);
        push_done(4'd2, 32'd1);
        do_start(4'd2, 32'd20);
        wait_done("restart_burst");

        // Data wrap from all-ones
        push_word(32'hFFFF_FFFF);
        push_word(32'h0000_0000);
        push_word(32'h0000_0001);
        push_done(4'd3, 32'hFFFF_FFFE);
        do_start(4'd3, 32'hFFFF_FFFF);
        wait_done("wrap_burst");

        // Zero-length burst completes without writing
        push_done(4'd0, 32'd0);
        do_start(4'd0, 32'd5);
        @(negedge wr_clock);
        check32("len0_done", {31'd0, done}, 32'd1);
        check32("len0_no_wr", {31'd0, wr_en}, 32'd0);
        @(posedge wr_clock);
        #1;

        // Start while busy is ignored
        push_word(32'd50);
        push_word(32'd51);
        push_word(32'd52);
        push_done(4'd3, 32'd53);
        do_start(4'd3, 32'd50);
        start     = 1'b1;
        burst_len = 4'd9;
        seed      = 32'd999;
        @(posedge wr_clock);
        #1;
        start = 1'b0;
        wait_done("busy_start_burst");

        // Start and abort together in IDLE: abort wins
        start     = 1'b1;
        abort     = 1'b1;
        burst_len = 4'd3;
        @(posedge wr_clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check32("start_abort_busy", {31'd0, busy}, 32'd0);

        // Reset mid-burst discards the burst
        push_word(32'd200);
        push_word(32'd201);
        do_start(4'd5, 32'd200);
        @(posedge wr_clock);
        #1;
        @(posedge wr_clock);
        #1;
        reset = 1'b0;
        @(negedge wr_clock);
        check32("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge wr_clock);
        #1;
        check32("midrst_busy", {31'd0, busy}, 32'd0);
        check32("midrst_done", {31'd0, done}, 32'd0);
        check32("midrst_data", data_in, 32'd0);
        check32("midrst_words", {28'd0, words_written}, 32'd0);
        check32("midrst_checksum", checksum, 32'd0);
        reset = 1'b1;
        @(posedge wr_clock);
        #1;

        // Almost-full: stalls only when throttling is compiled in
        fifo_almost_full = 1'b1;
        push_word(32'd7);
        push_word(32'd8);
        push_done(4'd2, 32'd15);
        do_start(4'd2, 32'd7);
`ifdef FIFO_WRITER_AF_THROTTLE_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clock);
            check32("af_stall_wr_en", {31'd0, wr_en}, 32'd0);
            @(posedge wr_clock);
            #1;
        end
        fifo_almost_full = 1'b0;
        wait_done("af_burst");
`else
        @(negedge wr_clock);
        check32("af_ignored_wr_en", {31'd0, wr_en}, 32'd1);
        wait_done("af_burst");
        fifo_almost_full = 1'b0;
`endif

        repeat (2) @(posedge wr_clock);
        #1;
        check32("data_queue_empty", 32'(exp_data_q.size()), 32'd0);
        check32("done_queue_empty", 32'(exp_words_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_burst_writer.md
FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of generated write data.
REQ-002 Parameter: LEN_WIDTH, 4, width of burst length and word counter.
REQ-003 Port: wr_clock  input  1  write-domain clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: start  input  1  request a new burst; sampled only in IDLE.
REQ-006 Port: abort  input  1  terminate the current burst.
REQ-007 Port: burst_len  input  LEN_WIDTH  number of words in the burst; sampled with start.
REQ-008 Port: seed  input  DATA_WIDTH  first data word of the burst; sampled with start.
REQ-009 Port: fifo_full  input  1  FIFO full flag, write-clock domain.
REQ-010 Port: fifo_almost_full  input  1  FIFO almost-full flag, write-clock domain.
REQ-011 Port: wr_en  output  1  FIFO write enable.
REQ-012 Port: data_in  output  DATA_WIDTH  FIFO write data, valid when wr_en=1.
REQ-013 Port: busy  output  1  high in WRITE and DONE states.
REQ-014 Port: done  output  1  one-cycle pulse on burst completion.
REQ-015 Port: words_written  output  LEN_WIDTH  words accepted in current or last burst.
REQ-016 Port: checksum  output  DATA_WIDTH  XOR of all words written in current or last burst.

Function
REQ-017 States: IDLE, WRITE, DONE; state, data_in, counters and checksum are registered.
REQ-018 IDLE: start=1, abort=0, burst_len>0 -> WRITE next cycle; load data_in=seed, remaining=burst_len, clear words_written and checksum.
REQ-019 IDLE: start=1 with burst_len=0 -> DONE next cycle, no write; words_written=0, checksum=0.
REQ-020 start while busy=1 is ignored; in IDLE, simultaneous start and abort -> abort wins, stay IDLE.
REQ-021 wr_en is combinational: wr_en = (state==WRITE) & ~fifo_full & ~abort & reset (plus the REQ-031 throttle term).
REQ-022 Each cycle with wr_en=1: data_in <= data_in+1 (modulo 2^DATA_WIDTH); remaining decrements; words_written increments; checksum ^= data_in.
REQ-023 When wr_en=1 and remaining=1 -> DONE next cycle.
REQ-024 WRITE with wr_en=0 due to the full flag: hold all state and data; no word is lost or duplicated.
REQ-025 DONE lasts exactly one cycle with done=1, then IDLE; done=0 in all other states.
REQ-026 abort=1 in WRITE -> IDLE next cycle, no wr_en in that cycle, no done pulse; words_written and checksum keep their partial values.
REQ-027 data_in wraps from all-ones to 0 without error; words_written never exceeds burst_len.

Reset
REQ-028 reset=0 at a rising edge -> state=IDLE, data_in=0, words_written=0, checksum=0, remaining=0, done=0.
REQ-029 wr_en=0 in any cycle with reset=0, including mid-burst; an interrupted burst is discarded and produces no done pulse.
REQ-030 busy=0 from the first edge after reset asserts until the next accepted start.

Configuration
REQ-031 Macro FIFO_WRITER_AF_THROTTLE_EN defined: wr_en is additionally gated by ~fifo_almost_full, so the writer stalls on almost-full.
REQ-032 Macro undefined: fifo_almost_full is ignored and only fifo_full stalls writes; all other behaviour is identical.

Verification
REQ-033 Reset, then start with burst_len=4, seed=10, FIFO never full -> wr_en high 4 consecutive cycles with data 10,11,12,13; done pulse next cycle; words_written=4; checksum=10^11^12^13=0.
REQ-034 burst_len=8, seed=1, fifo_full forced high during words 3-5 -> wr_en low while full; data sequence 1..8 unbroken; done after 8th word.
REQ-035 Start with burst_len=6, abort after 2 writes -> IDLE next cycle; no done pulse; words_written=2; a new start accepted next cycle.
REQ-036 seed=all-ones, burst_len=3 -> data_in sequence FFFFFFFF, 0, 1; burst_len=0 -> done one cycle after start with no wr_en.
REQ-037 Start during busy ignored; reset=0 mid-burst -> wr_en 0 in that cycle, all outputs at reset values next cycle.
REQ-038 fifo_almost_full=1, fifo_full=0 -> writes stall with FIFO_WRITER_AF_THROTTLE_EN defined and proceed without it.
